cargador_instrucciones: RTL and testbench
=========================================

CARGADOR_INSTRUCCIONES -- requirements
Module: cargador_instrucciones

Interface
REQ-001 Parameter NBITS, default 32: instruction word width.
REQ-002 Parameter ADDR_W, default 10: instruction-memory word-address width (depth 2^ADDR_W).
REQ-003 i_clk  in  1  single clock for all state; rising edge.
REQ-004 i_reset  in  1  asynchronous, active-low reset.
REQ-005 i_rx_data  in  8  received byte from UART receiver.
REQ-006 i_rx_valid  in  1  one-cycle pulse qualifying i_rx_data.
REQ-007 i_halt  in  1  CPU signals halt instruction executed.
REQ-008 o_mem_wr_en  out  1  instruction-memory write strobe.
REQ-009 o_mem_addr  out  ADDR_W  instruction-memory word address.
REQ-010 o_mem_data  out  NBITS  instruction-memory write data.
REQ-011 o_cpu_rst  out  1  active-high reset to CPU, held while loading.
REQ-012 o_cpu_en  out  1  CPU clock-enable (PC/register/memory update).
REQ-013 o_loaded  out  1  program present in memory.
REQ-014 o_halted  out  1  last run ended by halt or stop command.

Function
REQ-015 FSM states SHALL be IDLE, LEN, BYTES, WRITE, RUN, STEP.
REQ-016 IDLE: byte 0x4C ('L') -> LEN; 0x43 ('C') with o_loaded=1 -> RUN; 0x53 ('S') with o_loaded=1 -> STEP; any other byte ignored, state unchanged.
REQ-017 LEN: next byte SHALL be latched as word count N; N=0 -> IDLE with o_loaded unchanged; N>0 -> BYTES, word index=0, byte counter=0, o_loaded cleared.
REQ-018 BYTES: each valid byte SHALL shift into a 32-bit assembly register MSB-first; on the 4th byte -> WRITE.
REQ-019 WRITE: exactly one cycle with o_mem_wr_en=1, o_mem_addr=word index, o_mem_data=assembled word; index increments by 1 modulo 2^ADDR_W.
REQ-020 After WRITE: if words written == N -> IDLE with o_loaded=1; else -> BYTES; a byte with i_rx_valid in the WRITE cycle SHALL be captured as byte 0 of the next word (not dropped).
REQ-021 o_cpu_rst SHALL be 1 in LEN, BYTES and WRITE, and for exactly one cycle after the final WRITE; 0 otherwise.
REQ-022 RUN: o_cpu_en=1 every cycle; entry clears o_halted; i_halt=1 or byte 0x48 ('H') -> IDLE with o_halted=1, o_cpu_en=0 from the next cycle.
REQ-023 i_halt and a 0x48 byte in the same RUN cycle SHALL be treated as a single stop.
REQ-024 STEP: o_cpu_en=1 for exactly one cycle, then -> IDLE; if i_halt=1 in that cycle, o_halted=1.
REQ-025 o_mem_wr_en SHALL never be 1 outside WRITE; o_cpu_en SHALL never be 1 while o_cpu_rst=1.
REQ-026 i_halt SHALL be ignored outside RUN/STEP.

Reset
REQ-027 While i_reset=0, state SHALL be IDLE and all counters, assembly register and outputs 0 except o_cpu_rst=1.
REQ-028 o_cpu_rst SHALL drop to 0 on the first clock after i_reset deasserts.
REQ-029 Reset mid-load SHALL discard the partial word and leave o_loaded=0; no write strobe issued during or after reset.

Configuration
REQ-030 Macro STEP_MODE_EN: defined -> 'S' command and STEP state implemented per REQ-024; undefined -> STEP state absent, 0x53 ignored in IDLE like any unknown byte.

Verification
REQ-031 Reset, send 4C 02 12 34 56 78 9A BC DE F0 -> writes addr0=0x12345678, addr1=0x9ABCDEF0, one strobe each, o_loaded=1, o_cpu_rst 1 until one cycle after second write.
REQ-032 After load, send 0x43, assert i_halt on cycle 20 -> o_cpu_en high 20 cycles then 0, o_halted=1, state IDLE.
REQ-033 With STEP_MODE_EN, three 0x53 bytes -> exactly three single-cycle o_cpu_en pulses; without macro -> zero pulses.
REQ-034 Send 4C 03, 6 data bytes, pulse i_reset low -> no further strobes, o_loaded=0, subsequent 0x43 produces no o_cpu_en.
REQ-035 Load N=2 with byte 0 of word 1 arriving in the WRITE cycle of word 0 -> word 1 correct at addr1; load 4C 00 -> no strobe, o_loaded unchanged.

Source files
------------

// File: rtl/cargador_instrucciones.sv
// UART-driven program loader and CPU run/halt controller for an instruction memory.
// Define STEP_MODE_EN to add the 'S' single-step command and its STEP state.
module cargador_instrucciones #(
   parameter int NBITS  = 32,
   parameter int ADDR_W = 10
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic [7:0]        i_rx_data,
   input  logic              i_rx_valid,
   input  logic              i_halt,
   output logic              o_mem_wr_en,
   output logic [ADDR_W-1:0] o_mem_addr,
   output logic [NBITS-1:0]  o_mem_data,
   output logic              o_cpu_rst,
   output logic              o_cpu_en,
   output logic              o_loaded,
   output logic              o_halted
);

   localparam logic [7:0] CMD_LOAD = 8'h4C;
   localparam logic [7:0] CMD_CONT = 8'h43;
   localparam logic [7:0] CMD_HALT = 8'h48;
`ifdef STEP_MODE_EN
   localparam logic [7:0] CMD_STEP = 8'h53;
`endif

   typedef enum logic [2:0] {
      IDLE, LEN, BYTES, WRITE, RUN
`ifdef STEP_MODE_EN
      , STEP
`endif
   } state_t;

   state_t              state, state_nx;
   logic [7:0]          len_q, len_nx;
   logic [7:0]          wr_cnt, wr_cnt_nx;
   logic [ADDR_W-1:0]   idx, idx_nx;
   logic [1:0]          byte_cnt, byte_cnt_nx;
   logic [NBITS-1:0]    asm_q, asm_nx;
   logic                loaded_q, loaded_nx;
   logic                halted_q, halted_nx;
   logic                cpu_rst_q, cpu_rst_nx;
   logic                last_wr;

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         state     <= IDLE;
         len_q     <= '0;
         wr_cnt    <= '0;
         idx       <= '0;
         byte_cnt  <= '0;
         asm_q     <= '0;
         loaded_q  <= 1'b0;
         halted_q  <= 1'b0;
         cpu_rst_q <= 1'b1;
      end else begin
         state     <= state_nx;
         len_q     <= len_nx;
         wr_cnt    <= wr_cnt_nx;
         idx       <= idx_nx;
         byte_cnt  <= byte_cnt_nx;
         asm_q     <= asm_nx;
         loaded_q  <= loaded_nx;
         halted_q  <= halted_nx;
         cpu_rst_q <= cpu_rst_nx;
      end
   end

   always_comb begin
      state_nx    = state;
      len_nx      = len_q;
      wr_cnt_nx   = wr_cnt;
      idx_nx      = idx;
      byte_cnt_nx = byte_cnt;
      asm_nx      = asm_q;
      loaded_nx   = loaded_q;
      halted_nx   = halted_q;
      last_wr     = 1'b0;
      case (state)
         IDLE: begin
            if (i_rx_valid) begin
               if (i_rx_data == CMD_LOAD) begin
                  state_nx = LEN;
               end else if (i_rx_data == CMD_CONT && loaded_q) begin
                  state_nx  = RUN;
                  halted_nx = 1'b0;
               end
`ifdef STEP_MODE_EN
               else if (i_rx_data == CMD_STEP && loaded_q) begin
                  state_nx = STEP;
               end
`endif
            end
         end
         LEN: begin
            if (i_rx_valid) begin
               len_nx = i_rx_data;
               if (i_rx_data == 8'd0) begin
                  state_nx = IDLE;
               end else begin
                  state_nx    = BYTES;
                  idx_nx      = '0;
                  wr_cnt_nx   = '0;
                  byte_cnt_nx = '0;
                  loaded_nx   = 1'b0;
               end
            end
         end
         BYTES: begin
            if (i_rx_valid) begin
               asm_nx      = {asm_q[NBITS-9:0], i_rx_data};
               byte_cnt_nx = byte_cnt + 2'd1;
               if (byte_cnt == 2'd3) state_nx = WRITE;
            end
         end
         WRITE: begin
            idx_nx    = idx + ADDR_W'(1);
            wr_cnt_nx = wr_cnt + 8'd1;
            if (wr_cnt_nx == len_q) begin
               state_nx  = IDLE;
               loaded_nx = 1'b1;
               last_wr   = 1'b1;
            end else begin
               state_nx    = BYTES;
               byte_cnt_nx = '0;
               // A byte arriving alongside the strobe starts the next word.
               if (i_rx_valid) begin
                  asm_nx      = {asm_q[NBITS-9:0], i_rx_data};
                  byte_cnt_nx = 2'd1;
               end
            end
         end
         RUN: begin
            if (i_halt || (i_rx_valid && i_rx_data == CMD_HALT)) begin
               state_nx  = IDLE;
               halted_nx = 1'b1;
            end
         end
`ifdef STEP_MODE_EN
         STEP: begin
            state_nx = IDLE;
            if (i_halt) halted_nx = 1'b1;
         end
`endif
         default: state_nx = IDLE;
      endcase
      // Registered so the CPU stays in reset one cycle past the final write.
      cpu_rst_nx = last_wr || (state_nx inside {LEN, BYTES, WRITE});
   end

   assign o_mem_wr_en = (state == WRITE);
   assign o_mem_addr  = idx;
   assign o_mem_data  = asm_q;
   assign o_cpu_rst   = cpu_rst_q;
`ifdef STEP_MODE_EN
   assign o_cpu_en    = (state == RUN) || (state == STEP);
`else
   assign o_cpu_en    = (state == RUN);
`endif
   assign o_loaded    = loaded_q;
   assign o_halted    = halted_q;

endmodule

// File: tb/tb_cargador_instrucciones.sv
// Directed bench for cargador_instrucciones: load, run/halt, step, reset mid-load, back-to-back bytes.
module tb_cargador_instrucciones;

   localparam int NBITS  = 32;
   localparam int ADDR_W = 10;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [7:0]        rx_data;
   logic              rx_valid;
   logic              halt;
   logic              mem_wr_en;
   logic [ADDR_W-1:0] mem_addr;
   logic [NBITS-1:0]  mem_data;
   logic              cpu_rst;
   logic              cpu_en;
   logic              loaded;
   logic              halted;

   cargador_instrucciones #(.NBITS(NBITS), .ADDR_W(ADDR_W)) dut (
      .i_clk       (clk),
      .i_reset     (rst_n),
      .i_rx_data   (rx_data),
      .i_rx_valid  (rx_valid),
      .i_halt      (halt),
      .o_mem_wr_en (mem_wr_en),
      .o_mem_addr  (mem_addr),
      .o_mem_data  (mem_data),
      .o_cpu_rst   (cpu_rst),
      .o_cpu_en    (cpu_en),
      .o_loaded    (loaded),
      .o_halted    (halted)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   int cyc = 0, wr_count = 0, en_count = 0, en_rise = 0;
   int last_wr_cyc = 0, rst_fall_cyc = 0, wr_norst = 0, en_in_rst = 0;
   logic prev_rst = 1'b1, prev_en = 1'b0;
   logic [NBITS-1:0] bmem [0:(1<<ADDR_W)-1];
   logic [7:0] sb [0:15];

   // Passive observer of strobes, CPU enables and reset edges.
   always @(negedge clk) begin
      cyc     <= cyc + 1;
      prev_rst <= cpu_rst;
      prev_en  <= cpu_en;
      if (mem_wr_en) begin
         wr_count        <= wr_count + 1;
         bmem[mem_addr]  <= mem_data;
         last_wr_cyc     <= cyc;
         if (!cpu_rst) wr_norst <= wr_norst + 1;
      end
      if (cpu_en) en_count <= en_count + 1;
      if (cpu_en && !prev_en) en_rise <= en_rise + 1;
      if (cpu_en && cpu_rst) en_in_rst <= en_in_rst + 1;
      if (prev_rst && !cpu_rst) rst_fall_cyc <= cyc;
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   task automatic send_burst(input int n, input bit gap);
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
         rx_data  = sb[i];
         rx_valid = 1'b1;
         if (gap) begin
            @(posedge clk); #1;
            rx_valid = 1'b0;
         end
      end
      if (!gap) begin
         @(posedge clk); #1;
         rx_valid = 1'b0;
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      sb[0] = b;
      send_burst(1, 1'b1);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) @(negedge clk);
   endtask

   task automatic wait_en(output bit seen);
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (cpu_en) begin
            seen = 1'b1;
            break;
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      int wb, eb, rb;
      bit seen;
      int exp_steps;
      rst_n = 1'b0; rx_data = 8'h00; rx_valid = 1'b0; halt = 1'b0;
      idle(3);
      check("rst_cpu_rst", cpu_rst, 1);
      check("rst_cpu_en", cpu_en, 0);
      check("rst_loaded", loaded, 0);
      check("rst_halted", halted, 0);
      check("rst_wr_en", mem_wr_en, 0);
      check("rst_addr", mem_addr, 0);
      check("rst_data", mem_data, 0);
      @(posedge clk); #1 rst_n = 1'b1;
      @(negedge clk);
      check("rst_release_hold", cpu_rst, 1);
      @(negedge clk);
      check("rst_release_drop", cpu_rst, 0);

      // Gapped load of two words
      wb = wr_count;
      sb[0]=8'h4C; sb[1]=8'h02; sb[2]=8'h12; sb[3]=8'h34; sb[4]=8'h56;
      sb[5]=8'h78; sb[6]=8'h9A; sb[7]=8'hBC; sb[8]=8'hDE; sb[9]=8'hF0;
      send_burst(10, 1'b1);
      idle(4);
      check("load_strobes", wr_count - wb, 2);
      check("load_word0", bmem[0], 32'h12345678);
      check("load_word1", bmem[1], 32'h9ABCDEF0);
      check("load_loaded", loaded, 1);
      check("load_rst_tail", rst_fall_cyc - last_wr_cyc, 2);
      check("load_rst_low", cpu_rst, 0);
      check("load_halted", halted, 0);

      // Halt outside RUN is ignored
      @(posedge clk); #1 halt = 1'b1;
      @(posedge clk); #1 halt = 1'b0;
      idle(2);
      check("idle_halt_ignored", halted, 0);
      check("idle_no_en", cpu_en, 0);

      // Run, halt on the 20th enabled cycle
      eb = en_count;
      send_byte(8'h43);
      wait_en(seen);
      check("run_started", seen, 1);
      for (int i = 0; i < 19; i++) @(posedge clk);
      #1 halt = 1'b1;
      @(posedge clk); #1 halt = 1'b0;
      idle(5);
      check("run_en_cycles", en_count - eb, 20);
      check("run_halted", halted, 1);
      check("run_en_off", cpu_en, 0);

      // Run, then halt pin and 'H' byte together
      send_byte(8'h43);
      wait_en(seen);
      check("run2_started", seen, 1);
      check("run2_halted_clear", halted, 0);
      @(posedge clk); #1;
      rx_data = 8'h48; rx_valid = 1'b1; halt = 1'b1;
      @(posedge clk); #1;
      rx_valid = 1'b0; halt = 1'b0;
      @(negedge clk);
      eb = en_count;
      check("run2_en_off", cpu_en, 0);
      check("run2_halted", halted, 1);
      idle(5);
      check("run2_stays_idle", en_count - eb, 0);

      // Single-step commands
      eb = en_count; rb = en_rise;
      send_byte(8'h53); send_byte(8'h53); send_byte(8'h53);
      idle(4);
`ifdef STEP_MODE_EN
      exp_steps = 3;
`else
      exp_steps = 0;
`endif
      check("step_en_cycles", en_count - eb, exp_steps);
      check("step_pulses", en_rise - rb, exp_steps);

      // Reset in the middle of a load
      sb[0]=8'h4C; sb[1]=8'h03; sb[2]=8'h01; sb[3]=8'h02; sb[4]=8'h03;
      sb[5]=8'h04; sb[6]=8'h05; sb[7]=8'h06;
      send_burst(8, 1'b1);
      idle(1);
      wb = wr_count;
      @(posedge clk); #1 rst_n = 1'b0;
      @(negedge clk);
      check("midrst_cpu_rst", cpu_rst, 1);
      check("midrst_wr_en", mem_wr_en, 0);
      @(posedge clk); #1 rst_n = 1'b1;
      idle(6);
      check("midrst_strobes", wr_count - wb, 0);
      check("midrst_loaded", loaded, 0);
      eb = en_count;
      send_byte(8'h43);
      idle(10);
      check("midrst_no_run", en_count - eb, 0);

      // Back-to-back bytes: word 1 byte 0 lands in the write cycle of word 0
      wb = wr_count;
      sb[0]=8'h4C; sb[1]=8'h02; sb[2]=8'hA1; sb[3]=8'hB2; sb[4]=8'hC3;
      sb[5]=8'hD4; sb[6]=8'hE5; sb[7]=8'hF6; sb[8]=8'h07; sb[9]=8'h18;
      send_burst(10, 1'b0);
      idle(4);
      check("b2b_strobes", wr_count - wb, 2);
      check("b2b_word0", bmem[0], 32'hA1B2C3D4);
      check("b2b_word1", bmem[1], 32'hE5F60718);
      check("b2b_loaded", loaded, 1);

      // Zero-length load
      wb = wr_count;
      sb[0]=8'h4C; sb[1]=8'h00;
      send_burst(2, 1'b1);
      idle(4);
      check("len0_strobes", wr_count - wb, 0);
      check("len0_loaded", loaded, 1);
      check("len0_cpu_rst", cpu_rst, 0);
      send_byte(8'h43);
      wait_en(seen);
      check("len0_run", seen, 1);
      send_byte(8'h48);
      idle(2);
      check("len0_halted", halted, 1);

      check("inv_wr_without_rst", wr_norst, 0);
      check("inv_en_during_rst", en_in_rst, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
